// File: rtl/sync_evt_pkg.sv
// Shared definitions for the synchronizing event arbiter: parameter defaults,
// the channel-index width helper and the arbiter state encoding.
package sync_evt_pkg;

    localparam int N_CH_DEFAULT        = 4;
    localparam int FILT_CYCLES_DEFAULT = 8;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for one asynchronous input bit.
module sync_ff2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b0;
            stage <= 1'b0;
        end else begin
            meta  <= d;
            stage <= meta;
        end
    end

    assign q = stage;

endmodule

// File: rtl/sync_event_arbiter.sv
// Synchronizes and debounces N_CH asynchronous levels, turns accepted level
// changes into events and offers them one at a time with round-robin priority.
module sync_event_arbiter
    import sync_evt_pkg::*;
#(
    parameter int N_CH        = N_CH_DEFAULT,
    parameter int FILT_CYCLES = FILT_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       async_in,
    output logic [N_CH-1:0]       lvl,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [ch_w(N_CH)-1:0] evt_ch,
    output logic                  evt_rise,
    output logic [N_CH-1:0]       overrun,
    input  logic                  ovr_clr
);

    localparam int CH_W  = ch_w(N_CH);
    localparam int CNT_W = $clog2(FILT_CYCLES + 1);

    logic [N_CH-1:0]  synced;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  new_evt;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  pol;
    logic [N_CH-1:0]  grant_mask;
    logic [CH_W-1:0]  last_grant;
    logic [CH_W-1:0]  pick;
    logic             found;
    arb_state_t       state;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        sync_ff2 u_sync (
            .clk (clk),
            .rst (rst),
            .d   (async_in[g]),
            .q   (synced[g])
        );
    end

    // A change is accepted on the cycle its run of differing samples hits FILT_CYCLES.
    always_comb begin
        new_evt = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            new_evt[ch] = (synced[ch] != lvl[ch]) &&
                          (cnt[ch] == CNT_W'(FILT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (synced[ch] == lvl[ch]) begin
                    cnt[ch] <= '0;
                end else if (new_evt[ch]) begin
                    cnt[ch] <= '0;
                    lvl[ch] <= ~lvl[ch];
                end else begin
                    cnt[ch] <= cnt[ch] + CNT_W'(1);
                end
            end
        end
    end

    // Round-robin search starting just after the most recently granted channel.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!found && pending[(int'(last_grant) + i) % N_CH]) begin
                found = 1'b1;
                pick  = CH_W'((int'(last_grant) + i) % N_CH);
            end
        end
    end

    assign grant_mask = (state == ST_IDLE && found) ? (N_CH'(1) << pick) : '0;
    assign evt_valid  = (state == ST_OFFER);

    // A fresh event beats a same-cycle grant, so pending stays set and no overrun is flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pending    <= '0;
            pol        <= '0;
            overrun    <= '0;
            evt_ch     <= '0;
            evt_rise   <= 1'b0;
            last_grant <= CH_W'(N_CH - 1);
        end else begin
            pending <= (pending & ~grant_mask) | new_evt;
            pol     <= (pol & ~new_evt) | (~lvl & new_evt);
            overrun <= (ovr_clr ? '0 : overrun) | (new_evt & pending & ~grant_mask);
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        evt_ch   <= pick;
                        evt_rise <= pol[pick];
                        state    <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (evt_ready) begin
                        last_grant <= evt_ch;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Self-checking bench for sync_event_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural reference model.
module tb_sync_event_arbiter;

    localparam int N_CH = 4;
    localparam int FILT = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] async_in = '0;
    logic [N_CH-1:0] lvl;
    logic            evt_valid;
    logic            evt_ready = 1'b0;
    logic [1:0]      evt_ch;
    logic            evt_rise;
    logic [N_CH-1:0] overrun;
    logic            ovr_clr = 1'b0;

    int testCount = 0;
    int failCount = 0;
    int cycle     = 0;

    // Reference model state
    logic [N_CH-1:0] mSeen1, mSeen2;
    logic [N_CH-1:0] mLvl, mPend, mPol, mOvr;
    int              mRun [N_CH];
    bit              mOffer;
    int              mCh, mLast;
    bit              mRise;

    int evQ[$];
    int evCyc[$];

    sync_event_arbiter #(.N_CH(N_CH), .FILT_CYCLES(FILT)) dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .lvl       (lvl),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // One clock edge of the model; mSeen2 is the input as it looked two edges earlier.
    task automatic modelStep();
        logic [N_CH-1:0] fired;
        logic [N_CH-1:0] grantMask;
        if (rst) begin
            mSeen1 = '0; mSeen2 = '0; mLvl = '0; mPend = '0; mPol = '0; mOvr = '0;
            for (int c = 0; c < N_CH; c++) mRun[c] = 0;
            mOffer = 0; mCh = 0; mRise = 0; mLast = N_CH - 1;
            return;
        end
        fired = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (mSeen2[c] != mLvl[c]) begin
                mRun[c]++;
                if (mRun[c] == FILT) begin
                    fired[c] = 1'b1;
                    mRun[c]  = 0;
                end
            end else begin
                mRun[c] = 0;
            end
        end
        grantMask = '0;
        if (!mOffer) begin
            for (int k = 1; k <= N_CH; k++) begin
                int c;
                c = (mLast + k) % N_CH;
                if (mPend[c]) begin
                    mOffer = 1; mCh = c; mRise = mPol[c]; grantMask[c] = 1'b1;
                    break;
                end
            end
        end else if (evt_ready) begin
            mLast  = mCh;
            mOffer = 0;
        end
        mOvr  = (ovr_clr ? '0 : mOvr) | (fired & mPend & ~grantMask);
        mPend = (mPend & ~grantMask) | fired;
        for (int c = 0; c < N_CH; c++) begin
            if (fired[c]) begin
                mLvl[c] = ~mLvl[c];
                mPol[c] = mLvl[c];
            end
        end
        mSeen2 = mSeen1;
        mSeen1 = async_in;
    endtask

    task automatic checkCycle();
        checkOutput("lvl", 32'(lvl), 32'(mLvl));
        checkOutput("evt_valid", 32'(evt_valid), 32'(mOffer));
        checkOutput("overrun", 32'(overrun), 32'(mOvr));
        if (mOffer) begin
            checkOutput("evt_ch", 32'(evt_ch), 32'(mCh));
            checkOutput("evt_rise", 32'(evt_rise), 32'(mRise));
        end
    endtask

    // Drive one cycle of inputs, log any handshake, step the model and compare.
    task automatic applyStimulus(input logic [N_CH-1:0] a, input logic rdy,
                                 input logic clr, input logic r);
        async_in  = a;
        evt_ready = rdy;
        ovr_clr   = clr;
        rst       = r;
        if (!r && evt_valid && rdy) begin
            evQ.push_back(int'(evt_ch) * 2 + int'(evt_rise));
            evCyc.push_back(cycle);
        end
        @(posedge clk);
        modelStep();
        cycle++;
        @(negedge clk);
        checkCycle();
    endtask

    task automatic hold(input int n, input logic [N_CH-1:0] a, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(a, rdy, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        hold(3, '0, 1'b0);
        evQ.delete();
        evCyc.delete();
    endtask

    function automatic int evAt(input int i);
        return (i < evQ.size()) ? evQ[i] : -1;
    endfunction

    // Edges from the first sampling edge until evt_valid shows, bounded.
    task automatic edgesToValid(input logic [N_CH-1:0] a, output int edges);
        edges = 0;
        for (int i = 1; i <= 40 && edges == 0; i++) begin
            applyStimulus(a, 1'b1, 1'b0, 1'b0);
            if (evt_valid) edges = i;
        end
    endtask

    initial begin
        int edges;
        logic [N_CH-1:0] a;

        doReset();
        checkOutput("rst_lvl", 32'(lvl), 32'h0);
        checkOutput("rst_valid", 32'(evt_valid), 32'h0);
        checkOutput("rst_overrun", 32'(overrun), 32'h0);

        // Single rising change on channel 0
        edgesToValid(4'b0001, edges);
        checkOutput("latency_ch0", 32'(edges), 32'(FILT + 3));
        checkOutput("first_ch", 32'(evt_ch), 32'd0);
        checkOutput("first_rise", 32'(evt_rise), 32'd1);
        checkOutput("first_lvl0", 32'(lvl[0]), 32'd1);
        hold(5, 4'b0001, 1'b1);
        checkOutput("first_evcount", 32'(evQ.size()), 32'd1);

        // Glitch one short of the filter length, then one exactly long enough
        evQ.delete();
        hold(FILT - 1, 4'b0011, 1'b1);
        hold(20, 4'b0001, 1'b1);
        checkOutput("glitch_lvl1", 32'(lvl[1]), 32'd0);
        checkOutput("glitch_evcount", 32'(evQ.size()), 32'd0);
        hold(FILT, 4'b0011, 1'b1);
        hold(25, 4'b0001, 1'b1);
        checkOutput("pulse_evcount", 32'(evQ.size()), 32'd2);
        checkOutput("pulse_ev0", 32'(evAt(0)), 32'd3);
        checkOutput("pulse_ev1", 32'(evAt(1)), 32'd2);

        // All channels at once: round-robin from channel 0, one grant per 2 cycles
        doReset();
        hold(30, 4'b1111, 1'b1);
        checkOutput("rr_evcount", 32'(evQ.size()), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput("rr_order", 32'(evAt(i)), 32'(i * 2 + 1));
        for (int i = 1; i < 4 && i < evCyc.size(); i++)
            checkOutput("rr_spacing", 32'(evCyc[i] - evCyc[i-1]), 32'd2);

        // Same again after channel 1 was last granted
        doReset();
        hold(20, 4'b0010, 1'b1);
        evQ.delete();
        hold(30, 4'b1101, 1'b1);
        checkOutput("rr1_evcount", 32'(evQ.size()), 32'd4);
        checkOutput("rr1_ev0", 32'(evAt(0)), 32'd5);
        checkOutput("rr1_ev1", 32'(evAt(1)), 32'd7);
        checkOutput("rr1_ev2", 32'(evAt(2)), 32'd1);
        checkOutput("rr1_ev3", 32'(evAt(3)), 32'd2);

        // Overrun while the consumer stalls on channel 2
        doReset();
        hold(15, 4'b0100, 1'b0);
        hold(12, 4'b1100, 1'b0);
        hold(12, 4'b0100, 1'b0);
        checkOutput("ovr_set", 32'(overrun), 32'h8);
        checkOutput("ovr_hold_valid", 32'(evt_valid), 32'd1);
        checkOutput("ovr_hold_ch", 32'(evt_ch), 32'd2);
        hold(10, 4'b0100, 1'b1);
        checkOutput("ovr_evcount", 32'(evQ.size()), 32'd2);
        checkOutput("ovr_ev0", 32'(evAt(0)), 32'd5);
        checkOutput("ovr_ev1", 32'(evAt(1)), 32'd6);
        applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0);
        checkOutput("ovr_clr", 32'(overrun), 32'h0);

        // Reset in the middle of an offer, inputs held high through it
        doReset();
        hold(14, 4'b0110, 1'b0);
        checkOutput("mid_offer_valid", 32'(evt_valid), 32'd1);
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_mid_valid", 32'(evt_valid), 32'd0);
        checkOutput("rst_mid_lvl", 32'(lvl), 32'h0);
        evQ.delete();
        edgesToValid(4'b1111, edges);
        checkOutput("post_rst_latency", 32'(edges), 32'(FILT + 3));
        checkOutput("post_rst_ch", 32'(evt_ch), 32'd0);
        hold(20, 4'b1111, 1'b1);
        checkOutput("post_rst_ev0", 32'(evAt(0)), 32'd1);
        checkOutput("post_rst_evcount", 32'(evQ.size()), 32'd4);

        // Random traffic against the model
        doReset();
        a = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, 11) == 0) a[c] = ~a[c];
            applyStimulus(a, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                          $urandom_range(0, 499) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/sync_event_arbiter.md
SYNC_EVENT_ARBITER -- requirements
Module: sync_event_arbiter

Interface
REQ-001 SHALL have parameter: N_CH, 4, number of asynchronous input channels (2..16).
REQ-002 SHALL have parameter: FILT_CYCLES, 8, consecutive stable cycles required to accept a level change (1..255).
REQ-003 SHALL have port: clk  in  1  rising-edge clock.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: async_in  in  N_CH  raw asynchronous inputs.
REQ-006 SHALL have port: lvl  out  N_CH  filtered, synchronized level per channel.
REQ-007 SHALL have port: evt_valid  out  1  event offered.
REQ-008 SHALL have port: evt_ready  in  1  consumer accepts event.
REQ-009 SHALL have port: evt_ch  out  CH_W=clog2(N_CH)  channel of offered event.
REQ-010 SHALL have port: evt_rise  out  1  offered event polarity, 1=rising, 0=falling.
REQ-011 SHALL have port: overrun  out  N_CH  sticky per-channel lost-event flags.
REQ-012 SHALL have port: ovr_clr  in  1  clears all overrun bits.

Function
REQ-013 SHALL pass each async_in bit through a two-flop synchronizer; synced value valid 2 edges after sampling.
REQ-014 SHALL keep a per-channel counter, width clog2(FILT_CYCLES+1): cleared when synced==lvl, incremented when they differ.
REQ-015 SHALL toggle lvl[ch], clear its counter, set pending[ch] and capture polarity when the counter reaches FILT_CYCLES; a glitch shorter than FILT_CYCLES cycles produces no change.
REQ-016 SHALL, when a new event arrives on a channel whose pending bit is already set and not granted that cycle, set overrun[ch] and overwrite stored polarity with the newest.
REQ-017 SHALL arbitrate with a two-state FSM: IDLE, OFFER.
REQ-018 SHALL in IDLE, if any pending, pick the first pending channel searching round-robin from last_grant+1 (wrapping at N_CH-1 to 0), load evt_ch/evt_rise, clear that pending bit, go OFFER.
REQ-019 SHALL drive evt_valid=1 exactly in OFFER, holding evt_ch/evt_rise stable until evt_valid&&evt_ready.
REQ-020 SHALL on handshake set last_grant<=evt_ch and return to IDLE; maximum throughput one event per 2 cycles.
REQ-021 SHALL, if a new event on a channel coincides with that channel's grant, leave pending set (set wins), offer the older polarity, and not set overrun.
REQ-022 SHALL clear all overrun bits on ovr_clr; a simultaneous overrun set wins for that bit.
REQ-023 SHALL assert evt_valid on the (FILT_CYCLES+3)th edge after the first edge sampling a stable new input value, with no competing pending events (11 edges at default).

Reset
REQ-024 SHALL on rst clear synchronizer flops, lvl, counters, pending, polarity, overrun, evt_ch, evt_rise, evt_valid to 0, set state IDLE and last_grant=N_CH-1 (channel 0 has first priority).
REQ-025 SHALL abandon any in-flight offer on rst mid-OFFER; the event is discarded.
REQ-026 SHALL produce a rising event FILT_CYCLES+3 edges after rst release for any input held high through reset.

Structure
REQ-027 SHALL place N_CH/FILT_CYCLES defaults, CH_W function and FSM state enum in shared package sync_evt_pkg.
REQ-028 SHALL instantiate one sub-module sync_ff2 (two-flop synchronizer, ASYNC_REG attribute) per channel; filter, pending and arbiter stay in the top.

Verification
REQ-029 SHALL cover: async_in[0] 0->1 held, evt_ready=1 -> evt_valid at edge 11, evt_ch=0, evt_rise=1, lvl[0]=1.
REQ-030 SHALL cover: 7-cycle high pulse on async_in[1] -> no event, lvl[1] stays 0; 8-cycle pulse -> rise then fall events on channel 1.
REQ-031 SHALL cover: channels 0..3 change same cycle, evt_ready=1 -> grants 0,1,2,3 on alternating cycles; repeat with last_grant=1 -> order 2,3,0,1.
REQ-032 SHALL cover: evt_ready=0 holding channel 2 offer, channel 3 toggles twice -> overrun[3]=1, later event evt_rise reflects last level; ovr_clr -> overrun=0.
REQ-033 SHALL cover: rst asserted during OFFER -> evt_valid=0 next edge, all pending cleared, first post-reset grant from channel 0.
